// File: rtl/uart_tx_sched.sv
// uart_tx_sched: schedules bytes from a 64-bit block requester and a
// single-byte requester into the uart_tx serializer. Frames are timed
// locally because uart_tx has no busy output. Requesters are arbitrated
// round-robin at message boundaries.
// Optional feature macro: UART_TX_SYNC_EN, which prefixes every block with SYNC_BYTE.
module uart_tx_sched #(
   parameter int         FRAME_CYCLES = 11,
   parameter int         GAP_CYCLES   = 0,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        blk_valid,
   input  logic [63:0] blk_data,
   output logic        blk_ready,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        tx_data_valid,
   output logic [7:0]  tx_data,
   output logic        busy
);

   localparam int PERIOD = FRAME_CYCLES + GAP_CYCLES;
   localparam int CW     = $clog2(PERIOD);
   // SEND takes one cycle and the terminal WAIT cycle is the count of 0
   localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 2);

`ifdef UART_TX_SYNC_EN
   localparam int MSG_W = 72;
   localparam int BLK_N = 9;
`else
   localparam int MSG_W = 64;
   localparam int BLK_N = 8;
`endif

   localparam logic PRIO_BLK  = 1'b0;
   localparam logic PRIO_BYTE = 1'b1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t           state, state_nxt;
   logic             prio;
   logic [MSG_W-1:0] shreg;
   logic [MSG_W-1:0] msg_in;
   logic [3:0]       nbytes;
   logic [CW-1:0]    fcnt;
   logic             blk_acc, byte_acc;

   assign blk_acc  = blk_valid  & blk_ready;
   assign byte_acc = byte_valid & byte_ready;

   // Message as it enters the shift register; first byte to send in the top byte
`ifdef UART_TX_SYNC_EN
   assign msg_in = blk_acc ? {SYNC_BYTE, blk_data} : {byte_data, {(MSG_W-8){1'b0}}};
`else
   assign msg_in = blk_acc ? blk_data : {byte_data, {(MSG_W-8){1'b0}}};
   logic unused_sync;
   assign unused_sync = ^SYNC_BYTE;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (blk_acc || byte_acc) state_nxt = SEND;
         SEND: state_nxt = WAIT;
         WAIT: if (fcnt == '0) state_nxt = (nbytes != 4'd0) ? SEND : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; the readys grant only the prio side on contention
   always_comb begin
      blk_ready     = 1'b0;
      byte_ready    = 1'b0;
      tx_data_valid = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            busy       = 1'b0;
            blk_ready  = !rst && (!byte_valid || prio == PRIO_BLK);
            byte_ready = !rst && (!blk_valid  || prio == PRIO_BYTE);
         end
         SEND: tx_data_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: capture on accept, load tx_data on every entry to SEND, time each frame
   always_ff @(posedge clk) begin
      if (rst) begin
         prio    <= PRIO_BLK;
         shreg   <= '0;
         nbytes  <= '0;
         fcnt    <= '0;
         tx_data <= 8'h00;
      end else begin
         case (state)
            IDLE: if (blk_acc || byte_acc) begin
               prio    <= ~prio;
               tx_data <= msg_in[MSG_W-1 -: 8];
               shreg   <= msg_in << 8;
               nbytes  <= blk_acc ? 4'(BLK_N) : 4'd1;
            end
            SEND: begin
               fcnt   <= RELOAD;
               nbytes <= nbytes - 4'd1;
            end
            WAIT: begin
               if (fcnt != '0) begin
                  fcnt <= fcnt - CW'(1);
               end else if (nbytes != 4'd0) begin
                  tx_data <= shreg[MSG_W-1 -: 8];
                  shreg   <= shreg << 8;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a scoreboard of expected bytes (with
// their pulse slot) is filled when a request is driven and drained both at
// each tx_data_valid pulse and by a uart_tx line model plus receiver.
module tb_uart_tx_sched;

`ifdef UART_TX_SYNC_EN
   localparam int GAP  = 2;
   localparam int NB   = 9;
   localparam bit SYNC = 1'b1;
`else
   localparam int GAP  = 0;
   localparam int NB   = 8;
   localparam bit SYNC = 1'b0;
`endif
   localparam int PER = 11 + GAP;

   typedef struct {
      logic [7:0] d;
      int         k;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        blk_valid = 1'b0;
   logic [63:0] blk_data = '0;
   logic        blk_ready;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready;
   logic        tx_data_valid;
   logic [7:0]  tx_data;
   logic        busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   npulse = 0;
   logic [7:0] last_tx = '0;
   exp_t sq[$];
   logic [7:0] uq[$];

   uart_tx_sched #(.FRAME_CYCLES(11), .GAP_CYCLES(GAP), .SYNC_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst),
      .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .tx_data_valid(tx_data_valid), .tx_data(tx_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b, input int k);
      exp_t e;
      e.d = b;
      e.k = k;
      sq.push_back(e);
      uq.push_back(b);
   endtask

   task automatic push_msg(input logic is_blk, input logic [63:0] d);
      int k;
      k = 0;
      if (is_blk) begin
         if (SYNC) begin
            push(8'hA5, k);
            k++;
         end
         for (int i = 7; i >= 0; i--) begin
            push(d[i*8 +: 8], k);
            k++;
         end
      end else begin
         push(d[7:0], 0);
      end
   endtask

   // Wait for an accept; returns at cycle 1 (+1 time unit) of the message
   task automatic wait_grant(output logic got_blk, output logic [1:0] rdy);
      int n;
      n = 0;
      @(negedge clk);
      while (!(blk_valid && blk_ready) && !(byte_valid && byte_ready) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("grant_timeout", 64'(n < 2000), 64'd1);
      got_blk = blk_valid && blk_ready;
      rdy     = {blk_ready, byte_ready};
      tick();
   endtask

   // Called at cycle 1; checks the cycle on which busy drops
   task automatic wait_idle(input int nb);
      int r;
      r = 1;
      while (busy && r < 2000) begin
         tick();
         r++;
      end
      chk("idle_cycle", 64'(r), 64'(1 + nb*PER));
   endtask

   // Pulse monitor: data, slot timing, tx_data hold and readys low while busy
   always @(negedge clk) begin
      if ((blk_valid && blk_ready) || (byte_valid && byte_ready)) acc_cyc = cyc;
      if (tx_data_valid) begin
         npulse++;
         chk("pulse_expected", 64'(sq.size() != 0), 64'd1);
         if (sq.size() != 0) begin
            exp_t e;
            e = sq.pop_front();
            chk("tx_data", 64'(tx_data), 64'(e.d));
            chk("pulse_cycle", 64'(cyc - acc_cyc), 64'(1 + e.k*PER));
         end
         last_tx = tx_data;
      end else if (busy) begin
         chk("tx_hold", 64'(tx_data), 64'(last_tx));
      end
      if (busy) chk("ready_busy", 64'({blk_ready, byte_ready}), 64'd0);
   end

   // uart_tx line model: start, 8 data LSB first, stop, one bit per clock
   logic [9:0] u_sh = '1;
   int         u_cnt = 0;
   logic       u_line;
   assign u_line = (u_cnt != 0) ? u_sh[0] : 1'b1;
   always @(posedge clk) begin
      if (rst) begin
         u_cnt <= 0;
      end else if (tx_data_valid) begin
         u_sh  <= {1'b1, tx_data, 1'b0};
         u_cnt <= 10;
      end else if (u_cnt != 0) begin
         u_sh  <= u_sh >> 1;
         u_cnt <= u_cnt - 1;
      end
   end

   // Serial receiver decoding the model's line
   int         r_cnt = 0;
   logic [7:0] r_byte = '0;
   always @(negedge clk) begin
      if (rst) begin
         r_cnt = 0;
      end else if (r_cnt == 0) begin
         if (u_line === 1'b0) r_cnt = 1;
      end else if (r_cnt <= 8) begin
         r_byte[r_cnt-1] = u_line;
         r_cnt++;
      end else begin
         chk("uart_stop", 64'(u_line), 64'd1);
         chk("uart_expected", 64'(uq.size() != 0), 64'd1);
         if (uq.size() != 0) chk("uart_byte", 64'(r_byte), 64'(uq.pop_front()));
         r_cnt = 0;
      end
   end

   initial begin
      logic       g;
      logic [1:0] rdy;
      int         np0;

      // Reset held three cycles
      repeat (3) tick();
      chk("rst_tx_data", 64'(tx_data), 64'h00);
      chk("rst_tx_valid", 64'(tx_data_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_readys", 64'({blk_ready, byte_ready}), 64'd0);
      blk_data  = 64'h0123456789ABCDEF;
      blk_valid = 1'b1;
      #1;
      chk("rst_blk_ready", 64'(blk_ready), 64'd0);
      push_msg(1'b1, blk_data);
      tick();
      rst = 1'b0;
      #1;
      chk("first_blk_ready", 64'(blk_ready), 64'd1);

      // Block 0123456789ABCDEF
      wait_grant(g, rdy);
      blk_valid = 1'b0;
      chk("grant_blk", 64'(g), 64'd1);
      wait_idle(NB);

      // Single byte 3C
      byte_data  = 8'h3C;
      byte_valid = 1'b1;
      push_msg(1'b0, 64'h3C);
      wait_grant(g, rdy);
      byte_valid = 1'b0;
      chk("grant_byte", 64'(g), 64'd0);
      wait_idle(1);
      chk("ready_after_byte", 64'({blk_ready, byte_ready}), 64'd3);

      // Block of 11s
      blk_data  = 64'h1111111111111111;
      blk_valid = 1'b1;
      push_msg(1'b1, blk_data);
      wait_grant(g, rdy);
      blk_valid = 1'b0;
      wait_idle(NB);

      // Reset during the third pulse of a block
      blk_data  = 64'hFEDCBA9876543210;
      blk_valid = 1'b1;
      push_msg(1'b1, blk_data);
      wait_grant(g, rdy);
      blk_valid = 1'b0;
      repeat (2*PER) tick();
      chk("third_pulse", 64'(tx_data_valid), 64'd1);
      rst = 1'b1;
      tick();
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_tx_data", 64'(tx_data), 64'h00);
      chk("abort_tx_valid", 64'(tx_data_valid), 64'd0);
      sq.delete();
      uq.delete();
      rst = 1'b0;
      np0 = npulse;
      repeat (3*PER) tick();
      chk("no_pulse_after_rst", 64'(npulse - np0), 64'd0);

      // Both requesters valid: BLK, BYTE, BLK, then the lone byte requester
      blk_data   = 64'hA0A1A2A3A4A5A6A7;
      byte_data  = 8'h5A;
      blk_valid  = 1'b1;
      byte_valid = 1'b1;
      push_msg(1'b1, 64'hA0A1A2A3A4A5A6A7);
      push_msg(1'b0, 64'h5A);
      push_msg(1'b1, 64'hC0C1C2C3C4C5C6C7);
      push_msg(1'b0, 64'h69);
      wait_grant(g, rdy);
      chk("arb0_rdy", 64'(rdy), 64'd2);
      blk_data = 64'hC0C1C2C3C4C5C6C7;
      wait_grant(g, rdy);
      chk("arb1_rdy", 64'(rdy), 64'd1);
      byte_data = 8'h69;
      wait_grant(g, rdy);
      chk("arb2_rdy", 64'(rdy), 64'd2);
      blk_valid = 1'b0;
      wait_grant(g, rdy);
      chk("arb3_rdy", 64'(rdy), 64'd1);
      byte_valid = 1'b0;
      wait_idle(1);

      // Let the receiver finish the last frame, then the scoreboard must be empty
      repeat (PER + 2) tick();
      chk("sq_empty", 64'(sq.size()), 64'd0);
      chk("uq_empty", 64'(uq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Scheduler that feeds the `uart_tx` serializer on behalf of two requesters: the TEA core's 64-bit ciphertext block port and a single-byte status/debug port. `uart_tx` has no busy output and transmits one bit per clock. This block therefore:
- times each frame itself;
- pulses `data_valid` once per byte;
- holds the byte stable for the whole frame;
- arbitrates round-robin between requesters at message boundaries.

It sits between the cipher datapath and `uart_tx`, on the same clock and reset.

## Interface
Parameters:
- `FRAME_CYCLES`, 11: cycles from one `tx_data_valid` pulse to the earliest legal next pulse (START + 8 DATA + STOP + 1 IDLE sample). Values < 11 are illegal.
- `GAP_CYCLES`, 0: extra idle cycles inserted after every frame.
- `SYNC_BYTE`, 8'hA5: preamble byte, used only when `UART_TX_SYNC_EN` is defined.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `blk_valid` in 1: 64-bit block request.
- `blk_data` in 64: block, sent MSB byte (`[63:56]`) first.
- `blk_ready` out 1: block accepted on this cycle if `blk_valid` is high.
- `byte_valid` in 1: single-byte request.
- `byte_data` in 8: byte to send.
- `byte_ready` out 1: byte accepted on this cycle if `byte_valid` is high.
- `tx_data_valid` out 1: to `uart_tx.data_valid`; single-cycle pulse.
- `tx_data` out 8: to `uart_tx.data`; registered.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, SEND, WAIT.
- IDLE:
  - `blk_ready = !rst & (!byte_valid | prio==BLK)`.
  - `byte_ready = !rst & (!blk_valid | prio==BYTE)`.
  - At most one ready is high while both valids are high.
- Accept (valid & ready in IDLE):
  - Capture the message into the shift register and load the remaining-byte count: block = 8, byte = 1.
  - Flip `prio` to the other requester.
  - Go to SEND.
- `prio` changes only on an accept. With only one requester valid, that requester is granted, and `prio` still flips.
- SEND (1 cycle):
  - `tx_data` <= current byte; `tx_data_valid` = 1.
  - Load the frame counter with `FRAME_CYCLES+GAP_CYCLES-2`; go to WAIT.
- WAIT:
  - Count down; `tx_data` held constant.
  - At 0: if bytes remain, shift to the next byte and go to SEND; otherwise go to IDLE.
- Counter width is `$clog2(FRAME_CYCLES+GAP_CYCLES)`; no wrap is possible.
- Requesters hold valid/data stable until accepted. Data is not sampled after the accept cycle.
- Valid inputs outside IDLE are ignored (ready = 0).
- Reset: state IDLE, `prio` = BLK, count 0, `tx_data_valid` 0, `tx_data` 8'h00, `busy` 0, both readys 0.
- Reset mid-message aborts immediately. Remaining bytes are dropped, with no partial replay after reset. `uart_tx` shares `rst`, so the line returns to idle-high.

## Timing
- Accept on edge E (cycle 0). SEND is cycle 1, pulse at cycle 1.
- Pulse k (k = 0..N-1) occurs at cycle `1 + k*(FRAME_CYCLES+GAP_CYCLES)`.
- Return to IDLE (ready possible) at cycle `1 + N*(FRAME_CYCLES+GAP_CYCLES)`.
- With defaults:
  - byte: pulse at 1, IDLE at 12;
  - block: pulses at 1, 12, …, 78, IDLE at 89.
- `tx_data` changes only on entry to SEND. Relative to its pulse, it is stable for `FRAME_CYCLES+GAP_CYCLES` cycles.
- Back-to-back messages: the earliest next pulse is 1 cycle after IDLE re-entry (accept + SEND). The per-message gap is therefore one extra cycle.

## Configuration
- `UART_TX_SYNC_EN` defined: every accepted block is prefixed by `SYNC_BYTE`.
  - N = 9 frames, byte count loaded 9, `SYNC_BYTE` in the first SEND.
  - Single-byte requests are not prefixed.
  - Default block timing: IDLE at 100.
- `UART_TX_SYNC_EN` undefined: no prefix, block N = 8; the `SYNC_BYTE` parameter is unused.

## Test plan
- Reset then idle:
  - `rst` high 3 cycles -> `tx_data`=00, `tx_data_valid`=0, `busy`=0, readys 0.
  - Release with `blk_valid`=1 -> `blk_ready`=1 on the first cycle.
- Single byte 0x3C, defaults:
  - Pulse at cycle 1, `tx_data`=3C for cycles 1–11, `byte_ready` high again at cycle 12.
  - The `uart_tx` model's serial output decodes 0x3C (LSB first).
- Block 64'h0123456789ABCDEF:
  - Pulses at 1, 12, …, 78 carrying 01, 23, 45, 67, 89, AB, CD, EF.
  - `busy` 1 through cycle 88; decoded UART stream matches.
- Both valid continuously from reset:
  - Grants alternate BLK, BYTE, BLK; the loser's ready stays 0 until its turn.
  - No byte is lost or duplicated.
- Reset asserted at the 3rd pulse of a block:
  - The next cycle shows IDLE with `tx_data`=00.
  - No further pulses until a new accept.
- `UART_TX_SYNC_EN` with `GAP_CYCLES`=2:
  - Block 64'h1111…11 gives pulses every 13 cycles: A5 then eight 11.
  - IDLE at cycle 1+9*13=118.
